// File: rtl/nco_multi.sv
// Multi-channel NCO: CHANNELS phase accumulators sharing one byte-maskable
// waveform table. One table lookup per cycle, issued round-robin across the
// channels; table writes take priority and stall the round-robin for a cycle.
module nco_multi #(
   parameter int CHANNELS = 2,
   parameter int PHASE_W  = 12,
   parameter int INCR_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int OUT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CHANNELS-1:0]          enable,
   input  logic [CHANNELS-1:0]          updn,
   input  logic [CHANNELS-1:0]          preload,
   input  logic [CHANNELS*PHASE_W-1:0]  pl_data,
   input  logic [CHANNELS*INCR_W-1:0]   incr,
   input  logic                         phase_clr,
   input  logic                         csb0,
   input  logic                         web0,
   input  logic [DATA_W/8-1:0]          wmask0,
   input  logic [ADDR_W-1:0]            addr0,
   input  logic [DATA_W-1:0]            din0,
   output logic [CHANNELS*PHASE_W-1:0]  phase_out,
   output logic [CHANNELS*OUT_W-1:0]    sample_out,
   output logic [CHANNELS-1:0]          sample_valid
);

   localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int NBYTES = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;

   // Phase accumulators
   logic [PHASE_W-1:0] phase_q [CHANNELS];
   logic [PHASE_W-1:0] phase_d [CHANNELS];
   logic [PHASE_W-1:0] incr_ext;

   // Round-robin pointer and stage 0 (captured lookup request)
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               s0_valid_q, s0_valid_d;
   logic [SEL_W-1:0]   s0_sel_q, s0_sel_d;
   logic [ADDR_W-1:0]  s0_addr_q, s0_addr_d;

   // Stage 1 (table read) bookkeeping plus same-cycle write bypass
   logic               s1_valid_q, s1_valid_d;
   logic [SEL_W-1:0]   s1_sel_q, s1_sel_d;
   logic [NBYTES-1:0]  byp_mask_q, byp_mask_d;
   logic [DATA_W-1:0]  byp_data_q, byp_data_d;

   // Stage 2 outputs
   logic [OUT_W-1:0]    sample_q [CHANNELS];
   logic [OUT_W-1:0]    sample_d [CHANNELS];
   logic [CHANNELS-1:0] sample_valid_q, sample_valid_d;

   // Waveform table
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_rd_q;
   logic [DATA_W-1:0] rd_word;
   logic              wr_en;

   assign wr_en = ~csb0 & ~web0;

   // Next phase per channel: clear > preload > accumulate > hold, modulo 2^PHASE_W
   always_comb begin
      incr_ext = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         incr_ext = PHASE_W'(incr[c*INCR_W +: INCR_W]);
         if (phase_clr) begin
            phase_d[c] = '0;
         end else if (preload[c]) begin
            phase_d[c] = pl_data[c*PHASE_W +: PHASE_W];
         end else if (enable[c]) begin
            phase_d[c] = updn[c] ? (phase_q[c] - incr_ext) : (phase_q[c] + incr_ext);
         end else begin
            phase_d[c] = phase_q[c];
         end
      end
   end

   // Stage 0: capture the selected channel's pre-update address unless the table is being written
   always_comb begin
      sel_d      = sel_q;
      s0_valid_d = 1'b0;
      s0_sel_d   = s0_sel_q;
      s0_addr_d  = s0_addr_q;
      if (!wr_en) begin
         s0_valid_d = 1'b1;
         s0_sel_d   = sel_q;
         s0_addr_d  = phase_q[sel_q][PHASE_W-1 -: ADDR_W];
         sel_d      = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

   // Stage 1 control: forward the request and remember lanes written to the address being read
   always_comb begin
      s1_valid_d = s0_valid_q;
      s1_sel_d   = s0_sel_q;
      byp_data_d = din0;
      byp_mask_d = '0;
      if (wr_en && s0_valid_q && (addr0 == s0_addr_q)) begin
         byp_mask_d = wmask0;
      end
   end

   // Stage 2: update the owning channel's sample and pulse its valid
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         sample_d[c] = sample_q[c];
      end
      sample_valid_d = '0;
      if (s1_valid_q) begin
         sample_d[s1_sel_q]       = rd_word[DATA_W-1 -: OUT_W];
         sample_valid_d[s1_sel_q] = 1'b1;
      end
   end

   // Table storage: byte-masked write port, registered read port (not reset)
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wmask0[b]) begin
               mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end
         end
      end
      mem_rd_q <= mem[s0_addr_q];
   end

   // Pipeline and accumulator state; reset drops any in-flight lookups
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            phase_q[c]  <= '0;
            sample_q[c] <= '0;
         end
         sel_q          <= '0;
         s0_valid_q     <= 1'b0;
         s0_sel_q       <= '0;
         s0_addr_q      <= '0;
         s1_valid_q     <= 1'b0;
         s1_sel_q       <= '0;
         byp_mask_q     <= '0;
         byp_data_q     <= '0;
         sample_valid_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            phase_q[c]  <= phase_d[c];
            sample_q[c] <= sample_d[c];
         end
         sel_q          <= sel_d;
         s0_valid_q     <= s0_valid_d;
         s0_sel_q       <= s0_sel_d;
         s0_addr_q      <= s0_addr_d;
         s1_valid_q     <= s1_valid_d;
         s1_sel_q       <= s1_sel_d;
         byp_mask_q     <= byp_mask_d;
         byp_data_q     <= byp_data_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   // Read word with lanes written during the read cycle taken from the write data
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_rd_lane
      assign rd_word[gi*8 +: 8] = byp_mask_q[gi] ? byp_data_q[gi*8 +: 8] : mem_rd_q[gi*8 +: 8];
   end

   // Low word bits are below the sample field and intentionally dropped
   if (DATA_W > OUT_W) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^rd_word[DATA_W-OUT_W-1:0];
   end

   // Flatten per-channel state onto the packed output ports
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pack
      assign phase_out[gi*PHASE_W +: PHASE_W] = phase_q[gi];
      assign sample_out[gi*OUT_W +: OUT_W]    = sample_q[gi];
   end

   assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_nco_multi.sv
// Bench for nco_multi: cycle model with a sample scoreboard, a table of
// phase-update vectors, and directed sequences for table load, wrap, partial
// writes and mid-flight reset.
module tb_nco_multi;

   localparam int CH = 2;

   logic          clk;
   logic          reset;
   logic [1:0]    enable, updn, preload;
   logic [23:0]   pl_data;
   logic [15:0]   incr;
   logic          phase_clr, csb0, web0;
   logic [3:0]    wmask0;
   logic [7:0]    addr0;
   logic [31:0]   din0;
   logic [23:0]   phase_out;
   logic [31:0]   sample_out;
   logic [1:0]    sample_valid;

   nco_multi dut (
      .clk(clk), .reset(reset), .enable(enable), .updn(updn), .preload(preload),
      .pl_data(pl_data), .incr(incr), .phase_clr(phase_clr), .csb0(csb0), .web0(web0),
      .wmask0(wmask0), .addr0(addr0), .din0(din0), .phase_out(phase_out),
      .sample_out(sample_out), .sample_valid(sample_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [11:0] m_phase [CH];
   int          m_sel;
   logic [31:0] m_mem [256];
   bit          m_known [256];
   bit          pend_v;
   int          pend_ch;
   logic [7:0]  pend_addr;
   int          cyc = 0;

   typedef struct {
      int          due;
      int          ch;
      logic [15:0] data;
      bit          known;
   } sb_t;
   sb_t sb_q [$];

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      enable = '0; updn = '0; preload = '0; pl_data = '0; incr = '0;
      phase_clr = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
   endtask

   // Advance the model across one rising edge using the inputs currently driven
   task automatic model_edge();
      bit wr;
      logic [11:0] inc;
      logic [11:0] np [CH];
      cyc++;
      if (reset) begin
         for (int c = 0; c < CH; c++) m_phase[c] = '0;
         m_sel = 0;
         pend_v = 0;
         sb_q.delete();
         return;
      end
      wr = !csb0 && !web0;
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (wmask0[b]) m_mem[addr0][b*8 +: 8] = din0[b*8 +: 8];
         if (wmask0 == 4'hF) m_known[addr0] = 1'b1;
      end
      // Read happens on this edge, after this edge's write is visible
      if (pend_v)
         sb_q.push_back('{due: cyc + 1, ch: pend_ch, data: m_mem[pend_addr][31:16], known: m_known[pend_addr]});
      if (!wr) begin
         pend_v    = 1;
         pend_ch   = m_sel;
         pend_addr = m_phase[m_sel][11:4];
         m_sel     = (m_sel + 1) % CH;
      end else begin
         pend_v = 0;
      end
      for (int c = 0; c < CH; c++) begin
         inc = {4'b0, incr[c*8 +: 8]};
         if (phase_clr)        np[c] = '0;
         else if (preload[c])  np[c] = pl_data[c*12 +: 12];
         else if (enable[c])   np[c] = updn[c] ? m_phase[c] - inc : m_phase[c] + inc;
         else                  np[c] = m_phase[c];
      end
      for (int c = 0; c < CH; c++) m_phase[c] = np[c];
   endtask

   task automatic check_outputs();
      sb_t e;
      logic [1:0] exp_v;
      exp_v = 2'b00;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         exp_v = 2'b01 << e.ch;
         if (e.known) cmp("sample_out", 64'(sample_out[e.ch*16 +: 16]), 64'(e.data));
      end
      cmp("sample_valid", 64'(sample_valid), 64'(exp_v));
      cmp("phase_out", 64'(phase_out), 64'({m_phase[1], m_phase[0]}));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic wait_valid(input int ch, output logic [15:0] v);
      bit got;
      got = 0;
      v = '0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (sample_valid[ch]) begin
            v = sample_out[ch*16 +: 16];
            got = 1;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid ch%0d: no pulse within 10 cycles", ch);
      end
   endtask

   typedef struct {
      logic [11:0] s0, s1;
      logic [1:0]  en, ud, pl;
      logic        clr;
      logic [7:0]  i0, i1;
      logic [11:0] p0, p1, e0, e1;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [15:0] va, vb, dv;
      int vcount;

      vecs[0] = '{s0:12'hFF0, s1:12'h003, en:2'b11, ud:2'b10, pl:2'b00, clr:1'b0, i0:8'd16,  i1:8'd5,   p0:12'h000, p1:12'h000, e0:12'h000, e1:12'hFFE};
      vecs[1] = '{s0:12'h100, s1:12'h200, en:2'b01, ud:2'b00, pl:2'b00, clr:1'b0, i0:8'd0,   i1:8'd7,   p0:12'h000, p1:12'h000, e0:12'h100, e1:12'h200};
      vecs[2] = '{s0:12'h123, s1:12'h456, en:2'b11, ud:2'b00, pl:2'b01, clr:1'b1, i0:8'd1,   i1:8'd1,   p0:12'h777, p1:12'h000, e0:12'h000, e1:12'h000};
      vecs[3] = '{s0:12'h123, s1:12'h456, en:2'b11, ud:2'b00, pl:2'b10, clr:1'b0, i0:8'd1,   i1:8'd1,   p0:12'h000, p1:12'hABC, e0:12'h124, e1:12'hABC};
      vecs[4] = '{s0:12'h000, s1:12'hFFF, en:2'b11, ud:2'b01, pl:2'b00, clr:1'b0, i0:8'd1,   i1:8'd1,   p0:12'h000, p1:12'h000, e0:12'hFFF, e1:12'h000};
      vecs[5] = '{s0:12'h7F0, s1:12'h800, en:2'b11, ud:2'b00, pl:2'b00, clr:1'b0, i0:8'hFF,  i1:8'hFF,  p0:12'h000, p1:12'h000, e0:12'h8EF, e1:12'h8FF};
      vecs[6] = '{s0:12'h010, s1:12'h010, en:2'b10, ud:2'b11, pl:2'b00, clr:1'b0, i0:8'h20,  i1:8'h20,  p0:12'h000, p1:12'h000, e0:12'h010, e1:12'hFF0};
      vecs[7] = '{s0:12'h555, s1:12'hAAA, en:2'b00, ud:2'b11, pl:2'b00, clr:1'b0, i0:8'h33,  i1:8'h44,  p0:12'h000, p1:12'h000, e0:12'h555, e1:12'hAAA};

      for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
      idle();
      reset = 1'b1;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp("rst_phase", 64'(phase_out), 64'd0);
         cmp("rst_sample", 64'(sample_out), 64'd0);
         cmp("rst_valid", 64'(sample_valid), 64'd0);
      end
      $display("reset: outputs held at zero for 3 cycles");
      reset = 1'b0;

      // First pulses: ch0 on the third edge after release, then ch1
      tick();
      tick();
      tick();
      cmp("first_valid_ch0", 64'(sample_valid), 64'b01);
      tick();
      cmp("first_valid_ch1", 64'(sample_valid), 64'b10);
      $display("release: first sample_valid ch0 then ch1");

      // Table load mem[i] = {i, 24'h0}
      vcount = 0;
      for (int i = 0; i < 256; i++) begin
         csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
         addr0 = 8'(i); din0 = {8'(i), 24'h0};
         tick();
         if (i >= 2 && sample_valid != 2'b00) vcount++;
      end
      idle();
      cmp("load_no_valid", 64'(vcount), 64'd0);
      $display("table load: 256 words written, %0d stray pulses", vcount);

      // Preload ch0 to 0x120 with enable low
      preload = 2'b01; pl_data = {12'h000, 12'h120};
      tick();
      idle();
      tick(); tick(); tick();
      wait_valid(0, va);
      cmp("preload_sample", 64'(va), 64'h1200);
      $display("preload ch0=0x120: sample %h", va);

      // Upward wrap from 0xFF0 and address stepping
      preload = 2'b01; pl_data = {12'h000, 12'hFF0};
      tick();
      preload = 2'b00; enable = 2'b01; updn = 2'b00; incr = {8'd0, 8'd16};
      tick();
      cmp("wrap_up", 64'(phase_out[11:0]), 64'h000);
      tick(); tick(); tick();
      wait_valid(0, va);
      wait_valid(0, vb);
      dv = vb - va;
      cmp("step_diff", 64'(dv), 64'h0200);
      $display("incr 16 sweep: samples %h -> %h", va, vb);
      // Cross the table wrap (0xFF -> 0x00) while sampling
      for (int i = 0; i < 250; i++) tick();
      idle();
      tick();

      // Phase-update vectors
      foreach (vecs[v]) begin
         preload = 2'b11; pl_data = {vecs[v].s1, vecs[v].s0};
         tick();
         idle();
         enable = vecs[v].en; updn = vecs[v].ud; preload = vecs[v].pl;
         phase_clr = vecs[v].clr; incr = {vecs[v].i1, vecs[v].i0};
         pl_data = {vecs[v].p1, vecs[v].p0};
         tick();
         idle();
         cmp($sformatf("vec%0d_ph0", v), 64'(phase_out[11:0]), 64'(vecs[v].e0));
         cmp($sformatf("vec%0d_ph1", v), 64'(phase_out[23:12]), 64'(vecs[v].e1));
         $display("vector %0d: phase0 %h phase1 %h", v, phase_out[11:0], phase_out[23:12]);
      end

      // Partial write of the top byte at 0x12 under ch0 phase 0x120
      preload = 2'b01; pl_data = {12'h000, 12'h120};
      tick();
      idle();
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1000; addr0 = 8'h12; din0 = 32'hAB00_0000;
      tick();
      idle();
      tick(); tick(); tick();
      wait_valid(0, va);
      cmp("partial_top", 64'(va), 64'hAB00);
      $display("partial write top byte: sample %h", va);

      // Lane 2 written alone must keep lane 3
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h12; din0 = 32'h1234_5678;
      tick();
      wmask0 = 4'b0100; din0 = 32'h00EF_0000;
      tick();
      idle();
      tick(); tick(); tick();
      wait_valid(0, va);
      cmp("partial_lane2", 64'(va), 64'h12EF);
      $display("partial write lane 2: sample %h", va);

      // Write stall while reading the same address (bypass on read)
      tick();
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'h12; din0 = 32'h5A5A_0000;
      tick();
      idle();
      for (int i = 0; i < 6; i++) tick();
      $display("write stall during lookup: model-tracked");

      // Reset for one cycle with lookups in flight
      enable = 2'b11; incr = {8'd3, 8'd9};
      tick();
      idle();
      reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      cmp("midrst_phase", 64'(phase_out), 64'd0);
      tick();
      cmp("midrst_quiet1", 64'(sample_valid), 64'd0);
      tick();
      cmp("midrst_quiet2", 64'(sample_valid), 64'd0);
      tick();
      cmp("midrst_resume_ch0", 64'(sample_valid), 64'b01);
      tick();
      cmp("midrst_resume_ch1", 64'(sample_valid), 64'b10);
      $display("mid-flight reset: lookups resumed from ch0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
